apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB initiator bridging the CPU load/store port onto the APB fabric that feeds the address decoder. It accepts one request on a valid/ready interface and drives the APB SETUP/ACCESS sequence. It waits for `pready` or a watchdog timeout, then returns read data and an error flag on a held response interface.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `TIMEOUT`, default 255: maximum ACCESS cycles before forced error; 0 disables the watchdog.
- `pclk` input, 1 bit: clock; all logic is rising-edge.
- `presetn` input, 1 bit: reset, asynchronous, active-low.
- `req_valid` input, 1 bit: CPU request present.
- `req_ready` output, 1 bit: bridge accepts a request this cycle.
- `req_addr` input, ADDR_WIDTH: request address.
- `req_wdata` input, DATA_WIDTH: write data.
- `req_write` input, 1 bit: 1 means write, 0 means read.
- `req_strb` input, 4 bits: byte strobes for writes.
- `rsp_valid` output, 1 bit: response present.
- `rsp_ready` input, 1 bit: CPU takes the response.
- `rsp_rdata` output, DATA_WIDTH: read data; 0 for writes and errors.
- `rsp_err` output, 1 bit: slave error or timeout.
- `rsp_timeout` output, 1 bit: the error was caused by the watchdog.
- `paddr` output, ADDR_WIDTH: APB address.
- `pdata` output, DATA_WIDTH: APB write data.
- `pwrite` output, 1 bit: APB direction.
- `pstb` output, 4 bits: APB strobes; forced to 0 on reads.
- `psel` output, 1 bit: APB select.
- `penable` output, 1 bit: APB enable.
- `prdata` input, DATA_WIDTH: APB read data.
- `pready` input, 1 bit: APB completion.
- `perr` input, 1 bit: APB error; sampled only together with `pready`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register addr, wdata, write and strb (strb masked to 0 if read), then go to SETUP.
- SETUP:
  - `psel`=1, `penable`=0.
  - Always go to ACCESS next cycle.
  - Clear the watchdog counter.
- ACCESS:
  - `psel`=1, `penable`=1.
  - If `pready`: capture `rsp_rdata` = write ? 0 : `prdata`, `rsp_err` = `perr`, `rsp_timeout` = 0, then go to RESP.
  - Otherwise increment the counter.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT−1 without `pready`, capture rdata=0, err=1, timeout=1, then go to RESP.
  - `pready` in the same cycle as timeout expiry wins; the response is a normal completion.
- RESP:
  - `psel`=`penable`=0, `rsp_valid`=1.
  - Response fields hold stable until `rsp_ready`, then go to IDLE.
  - `req_ready`=0, so back-to-back transfers have one idle cycle.
- `paddr`, `pdata`, `pwrite` and `pstb` hold the registered request from SETUP through the ACCESS exit.
- The `paddr`, `pdata`, `pwrite` and `pstb` registers update only on acceptance and otherwise keep their last value.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.

## Timing
- Reset (async assert, sync deassert by the clock domain):
  - state=IDLE.
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err` and `rsp_timeout` = 0.
  - `paddr`, `pdata`, `pstb` and `rsp_rdata` = 0.
  - Counter = 0.
- Assertion mid-transfer aborts it immediately: `psel` drops asynchronously and no response is produced.
- Zero-wait latency: accept at edge 0, SETUP at cycle 1, ACCESS at cycle 2 with `pready`, `rsp_valid` at cycle 3.
- Each slave wait state adds one cycle.
- Timeout response appears TIMEOUT cycles after ACCESS entry.
- `req_ready` is a function of state only; there is no combinational path from `req_valid`.
- `rsp_valid` is registered.
- All APB outputs are registered or derived from the state register only; there are no combinational paths from `pready` or `prdata`.

## Structure
- Shared package `apb_pkg`:
  - `apb_state_t` enum {IDLE, SETUP, ACCESS, RESP}.
  - STRB_W=4.
  - Default TIMEOUT constant.
- One sub-module is natural: `apb_watchdog`, a saturating counter with clear, enable and TIMEOUT compare that outputs `expired`. All else stays in `apb_master`.

## Test plan
- Read, zero wait: req addr=0x80000010, slave pready at first ACCESS with prdata=0xDEADBEEF -> `psel` high 2 cycles, `penable` 1 cycle, `rsp_valid` 3 cycles after accept, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Write, 2 wait states: addr=0x01000000, wdata=0x41, strb=0x1 -> ACCESS lasts 3 cycles, `pdata`/`pstb`/`paddr` stable throughout, `rsp_rdata`=0, `rsp_err`=0.
- Slave error: read addr=0x2000 with pready=1, perr=1 at first ACCESS -> `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- Timeout: TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then `psel`=0, `rsp_err`=1, `rsp_timeout`=1.
- Timeout race: TIMEOUT=4, pready=1 on the 4th ACCESS cycle -> normal completion, `rsp_timeout`=0.
- Response backpressure and reset:
  - `rsp_ready` held 0 for 5 cycles -> `rsp_valid` and fields stable, `req_ready`=0. Then one cycle of `rsp_ready` -> IDLE, and a new request is accepted the next cycle.
  - `presetn` pulled low during ACCESS -> `psel`/`penable` 0 immediately, and no `rsp_valid` after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  localparam int STRB_W          = 4;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/apb_watchdog.sv
// Saturating ACCESS-phase cycle counter; expired flags the final allowed cycle.
module apb_watchdog
  import apb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sat_inc(cnt);
    end
  end

  // TIMEOUT of zero disables the watchdog entirely.
  assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready request in, held response out.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [STRB_W-1:0]     req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [STRB_W-1:0]     pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr
);

  apb_state_t state_q, state_d;
  logic       accept;
  logic       expired;
  logic       in_access;

  assign accept    = (state_q == IDLE) && req_valid;
  assign in_access = (state_q == ACCESS);

  apb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (state_q == SETUP),
    .en      (in_access && !pready),
    .expired (expired)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // APB strobes come straight off the state register, so reset drops them at once.
  always_comb begin
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      SETUP:   psel      = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr  <= '0;
      pdata  <= '0;
      pwrite <= 1'b0;
      pstb   <= '0;
    end else if (accept) begin
      paddr  <= req_addr;
      pdata  <= req_wdata;
      pwrite <= req_write;
      pstb   <= req_write ? req_strb : '0;
    end
  end

  // A real pready in the expiry cycle is treated as a normal completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (in_access && pready) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= (pwrite || perr) ? '0 : prdata;
      rsp_err     <= perr;
      rsp_timeout <= 1'b0;
    end else if (in_access && expired) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end else if ((state_q == RESP) && rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a TIMEOUT=4 watchdog and a scripted APB slave.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pdata, prdata;
  logic        pwrite, psel, penable, pready, perr;
  logic [3:0]  pstb;

  int checks = 0;
  int errors = 0;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .perr(perr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ws;
    logic [31:0] prdata;
    logic        perr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    logic [3:0]  exp_pstb;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues the request and plays the slave until the bridge leaves ACCESS.
  task automatic run_to_resp(input vec_t v, output int acc);
    bit ok;
    @(negedge pclk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_write = v.write;
    req_strb  = v.strb;
    @(negedge pclk);
    req_valid = 1'b0;
    chk("setup_psel", {31'b0, psel}, 32'd1);
    chk("setup_penable", {31'b0, penable}, 32'd0);
    chk("setup_pstb", {28'b0, pstb}, {28'b0, v.exp_pstb});
    acc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (psel && penable) begin
        pready = (acc == v.ws);
        prdata = v.prdata;
        perr   = v.perr;
        acc++;
        chk("access_paddr", paddr, v.addr);
        chk("access_pdata", pdata, v.wdata);
        chk("access_pstb", {28'b0, pstb}, {28'b0, v.exp_pstb});
        chk("access_pwrite", {31'b0, pwrite}, {31'b0, v.write});
      end else begin
        pready = 1'b0;
        perr   = 1'b0;
        ok     = 1'b1;
        break;
      end
    end
    chk("resp_reached", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int   acc;
    vec_t bp;

    vecs[0] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'hF, 0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0, 1};
    vecs[1] = '{1'b1, 32'h0100_0000, 32'h0000_0041, 4'h1, 2,  32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 4'h1, 3};
    vecs[2] = '{1'b0, 32'h0000_2000, 32'h0000_0000, 4'h0, 0,  32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 4'h0, 1};
    vecs[3] = '{1'b0, 32'h0000_4000, 32'h0000_0000, 4'h0, 99, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4'h0, 4};
    vecs[4] = '{1'b0, 32'h0000_5000, 32'h0000_0000, 4'h0, 3,  32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 1'b0, 1'b0, 4'h0, 4};
    vecs[5] = '{1'b0, 32'h0000_6004, 32'hA5A5_A5A5, 4'hA, 1,  32'h7777_0001, 1'b0, 32'h7777_0001, 1'b0, 1'b0, 4'h0, 2};
    vecs[6] = '{1'b1, 32'h0000_7008, 32'h0BEE_F000, 4'hC, 99, 32'h2222_2222, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4'hC, 4};

    presetn   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = 1'b0;
    req_strb  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    perr      = 1'b0;

    repeat (3) @(negedge pclk);
    chk("rst_psel", {31'b0, psel}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pdata", pdata, 32'd0);
    chk("rst_pstb", {28'b0, pstb}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    presetn = 1'b1;

    for (int k = 0; k < 7; k++) begin
      run_to_resp(vecs[k], acc);
      chk("resp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("resp_psel", {31'b0, psel}, 32'd0);
      chk("resp_penable", {31'b0, penable}, 32'd0);
      chk("resp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("resp_rdata", rsp_rdata, vecs[k].exp_rdata);
      chk("resp_err", {31'b0, rsp_err}, {31'b0, vecs[k].exp_err});
      chk("resp_timeout", {31'b0, rsp_timeout}, {31'b0, vecs[k].exp_to});
      chk("access_cycles", acc, vecs[k].exp_acc);
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
      chk("post_resp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("post_req_ready", {31'b0, req_ready}, 32'd1);
    end

    // Response backpressure followed by an immediate next request.
    bp = '{1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 32'h55AA_55AA, 1'b0, 32'h55AA_55AA, 1'b0, 1'b0, 4'h0, 2};
    run_to_resp(bp, acc);
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h55AA_55AA);
      chk("bp_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("bp_idle_req_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    req_valid = 1'b1;
    req_addr  = 32'h0000_3100;
    req_write = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    chk("bp_next_setup_psel", {31'b0, psel}, 32'd1);
    chk("bp_next_paddr", paddr, 32'h0000_3100);
    @(negedge pclk);
    chk("bp_next_access", {31'b0, penable}, 32'd1);
    pready = 1'b1;
    prdata = 32'h0000_00AB;
    @(negedge pclk);
    pready = 1'b0;
    chk("bp_next_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_next_rdata", rsp_rdata, 32'h0000_00AB);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;

    // Reset asserted mid-ACCESS aborts the transfer without a response.
    req_valid = 1'b1;
    req_addr  = 32'h0000_9000;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("abort_in_access", {31'b0, psel & penable}, 32'd1);
    #1 presetn = 1'b0;
    #1;
    chk("abort_psel_async", {31'b0, psel}, 32'd0);
    chk("abort_penable_async", {31'b0, penable}, 32'd0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("abort_idle_psel", {31'b0, psel}, 32'd0);
      chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
